// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - FP format constants, field helpers and fp2int stage structs
package fp_pkg;

    localparam int FP_EXPONENT_WIDTH = 5;
    localparam int FP_MANTISSA_WIDTH = 11;
    localparam int BIAS              = 2**(FP_EXPONENT_WIDTH-1) - 1;
    localparam int DATA_WIDTH        = FP_EXPONENT_WIDTH + FP_MANTISSA_WIDTH;

    typedef enum logic [1:0] {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN} fp_class_e;

    typedef struct packed {
        logic      sign;
        fp_class_e cls;
        logic      big;
        logic      sub_inexact;
    } s1_s2_t;

    typedef struct packed {
        logic      sign;
        fp_class_e cls;
        logic      big;
        logic      sub_inexact;
        logic      guard;
        logic      sticky;
    } s2_s3_t;

    function automatic logic fp_sign(input logic [DATA_WIDTH-1:0] data);
        return data[DATA_WIDTH-1];
    endfunction

    function automatic logic [FP_EXPONENT_WIDTH-1:0] fp_exponent(input logic [DATA_WIDTH-1:0] data);
        return data[DATA_WIDTH-2 -: FP_EXPONENT_WIDTH];
    endfunction

    function automatic logic [FP_MANTISSA_WIDTH-2:0] fp_fraction(input logic [DATA_WIDTH-1:0] data);
        return data[FP_MANTISSA_WIDTH-2:0];
    endfunction

endpackage

// File: rtl/fp2int_aligner.sv
// rtl/fp2int_aligner.sv - combinational bidirectional shifter: significand to integer magnitude plus guard/sticky
module fp2int_aligner #(
    parameter int EXPONENT_WIDTH = 5,
    parameter int MANTISSA_WIDTH = 11,
    parameter int INT_WIDTH      = 32
) (
    input  logic [MANTISSA_WIDTH-1:0]        sig_i,
    input  logic signed [EXPONENT_WIDTH:0]   exp_i,
    output logic [INT_WIDTH-1:0]             mag_o,
    output logic                             guard_o,
    output logic                             sticky_o
);

    localparam int EXT_W = 2*MANTISSA_WIDTH + 1;

    logic signed [31:0] exp_ext;
    logic [31:0]        shamt;
    logic [EXT_W-1:0]   shifted;

    assign exp_ext = 32'(exp_i);

    always_comb begin
        mag_o    = '0;
        guard_o  = 1'b0;
        sticky_o = 1'b0;
        shamt    = '0;
        shifted  = '0;
        if (exp_ext >= MANTISSA_WIDTH - 1) begin
            shamt = 32'(exp_ext - (MANTISSA_WIDTH - 1));
            mag_o = INT_WIDTH'(sig_i) << shamt;
        end else begin
            // Past MANTISSA_WIDTH+1 every significand bit is already below the guard position.
            shamt = 32'((MANTISSA_WIDTH - 1) - exp_ext);
            if (shamt > 32'(MANTISSA_WIDTH + 1)) begin
                shamt = 32'(MANTISSA_WIDTH + 1);
            end
            shifted  = {sig_i, {(MANTISSA_WIDTH+1){1'b0}}} >> shamt;
            mag_o    = INT_WIDTH'(shifted[EXT_W-1:MANTISSA_WIDTH+1]);
            guard_o  = shifted[MANTISSA_WIDTH];
            sticky_o = |shifted[MANTISSA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fp2int.sv
// rtl/fp2int.sv - 3-stage FP to signed integer converter; FP2INT_RNE_EN selects round-nearest-even, else truncate
module fp2int
    import fp_pkg::*;
#(
    parameter int EXPONENT_WIDTH = FP_EXPONENT_WIDTH,
    parameter int MANTISSA_WIDTH = FP_MANTISSA_WIDTH,
    parameter int INT_WIDTH      = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] data_i,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic [INT_WIDTH-1:0]                   result_o,
    output logic                                   invalid_o,
    output logic                                   inexact_o
);

    localparam int DW       = EXPONENT_WIDTH + MANTISSA_WIDTH;
    localparam int FW       = MANTISSA_WIDTH - 1;
    localparam int EXP_BIAS = 2**(EXPONENT_WIDTH-1) - 1;
    localparam logic [INT_WIDTH:0] MAX_POS = {2'b00, {(INT_WIDTH-1){1'b1}}};
    localparam logic [INT_WIDTH:0] MAX_NEG = {2'b01, {(INT_WIDTH-1){1'b0}}};

    logic                          en;
    logic                          in_sign;
    logic [EXPONENT_WIDTH-1:0]     in_exp;
    logic [FW-1:0]                 in_frac;
    logic signed [EXPONENT_WIDTH:0] in_e;
    s1_s2_t                        s1_d, s1_q;
    logic signed [EXPONENT_WIDTH:0] e1_q;
    logic [FW-1:0]                 frac1_q;
    s2_s3_t                        s2_d, s2_q;
    logic [INT_WIDTH-1:0]          mag2_d, mag2_q;
    logic                          guard2_d, sticky2_d;
    logic                          round_up;
    logic [INT_WIDTH:0]            rmag;
    logic [INT_WIDTH-1:0]          result_d, result_q;
    logic                          invalid_d, invalid_q, inexact_d, inexact_q;
    logic                          valid1_q, valid2_q, valid3_q;

    assign en      = ~valid3_q | ready_i;
    assign ready_o = en;

    assign in_sign = data_i[DW-1];
    assign in_exp  = data_i[DW-2:FW];
    assign in_frac = data_i[FW-1:0];
    assign in_e    = signed'({1'b0, in_exp}) - signed'((EXPONENT_WIDTH+1)'(EXP_BIAS));

    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_sign;
        s1_d.cls  = FP_NORMAL;
        if (in_exp == '0) begin
            s1_d.cls         = FP_ZERO;
            s1_d.sub_inexact = |in_frac;
        end else if (&in_exp) begin
            s1_d.cls = (|in_frac) ? FP_NAN : FP_INF;
        end
        // At or above 2**INT_WIDTH the magnitude cannot even be held unsigned.
        s1_d.big = (32'(in_e) >= INT_WIDTH);
    end

    fp2int_aligner #(
        .EXPONENT_WIDTH(EXPONENT_WIDTH),
        .MANTISSA_WIDTH(MANTISSA_WIDTH),
        .INT_WIDTH     (INT_WIDTH)
    ) u_aligner (
        .sig_i   ({1'b1, frac1_q}),
        .exp_i   (e1_q),
        .mag_o   (mag2_d),
        .guard_o (guard2_d),
        .sticky_o(sticky2_d)
    );

    assign s2_d = '{sign: s1_q.sign, cls: s1_q.cls, big: s1_q.big,
                    sub_inexact: s1_q.sub_inexact, guard: guard2_d, sticky: sticky2_d};

`ifdef FP2INT_RNE_EN
    assign round_up = s2_q.guard & (s2_q.sticky | mag2_q[0]);
`else
    assign round_up = 1'b0;
`endif
    assign rmag = {1'b0, mag2_q} + (INT_WIDTH+1)'(round_up);

    always_comb begin
        result_d  = '0;
        invalid_d = 1'b0;
        inexact_d = 1'b0;
        case (s2_q.cls)
            FP_ZERO: inexact_d = s2_q.sub_inexact;
            FP_NAN: begin
                result_d  = MAX_POS[INT_WIDTH-1:0];
                invalid_d = 1'b1;
            end
            FP_INF: begin
                result_d  = s2_q.sign ? MAX_NEG[INT_WIDTH-1:0] : MAX_POS[INT_WIDTH-1:0];
                invalid_d = 1'b1;
            end
            default: begin
                // The most negative integer is one step further from zero than the most positive.
                if (s2_q.big || rmag > (s2_q.sign ? MAX_NEG : MAX_POS)) begin
                    result_d  = s2_q.sign ? MAX_NEG[INT_WIDTH-1:0] : MAX_POS[INT_WIDTH-1:0];
                    invalid_d = 1'b1;
                end else begin
                    result_d  = s2_q.sign ? -rmag[INT_WIDTH-1:0] : rmag[INT_WIDTH-1:0];
                    inexact_d = s2_q.guard | s2_q.sticky;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid1_q  <= 1'b0;
            valid2_q  <= 1'b0;
            valid3_q  <= 1'b0;
            s1_q      <= '0;
            e1_q      <= '0;
            frac1_q   <= '0;
            s2_q      <= '0;
            mag2_q    <= '0;
            result_q  <= '0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
        end else if (en) begin
            valid1_q  <= valid_i;
            s1_q      <= s1_d;
            e1_q      <= in_e;
            frac1_q   <= in_frac;
            valid2_q  <= valid1_q;
            s2_q      <= s2_d;
            mag2_q    <= mag2_d;
            valid3_q  <= valid2_q;
            result_q  <= result_d;
            invalid_q <= invalid_d;
            inexact_q <= inexact_d;
        end
    end

    assign valid_o   = valid3_q;
    assign result_o  = result_q;
    assign invalid_o = invalid_q;
    assign inexact_o = inexact_q;

endmodule
